// File: rtl/jala_io_responder.sv
// Memory-mapped I/O responder: inbound FIFO (DATA_IN), one-word outbound holding register (DATA_OUT), STATUS register.
// Latency: ACK one cycle after the accepted request edge; a DATA_OUT store adds one cycle per cycle the held word stalls.
// Backpressure: IN_READY drops while the FIFO is full; a DATA_OUT store waits in WAIT_OUT until the consumer drains the held word.
module jala_io_responder #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sel_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ack_o,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [1:0] ADDR_DIN  = 2'd0;
  localparam logic [1:0] ADDR_DOUT = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_OUT = 2'd1,
    ST_ACK      = 2'd2
  } state_t;

  state_t            state_q;
  logic              ack_q;
  logic [DATA_W-1:0] rdata_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              underflow_q;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              fifo_empty;
  logic              fifo_full;
  logic              req_vld;
  logic              push;
  logic              pop;
  logic              out_busy;
  logic [DATA_W-1:0] status_w;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign req_vld    = (state_q == ST_IDLE) && sel_i && req_i;
  // Ready is taken from the pre-pop count, so a full FIFO never pushes even when a pop frees a slot this cycle.
  assign push       = in_valid_i && !fifo_full;
  assign pop        = req_vld && !we_i && (addr_i == ADDR_DIN) && !fifo_empty;
  // A held word the consumer is not taking this cycle blocks a new DATA_OUT store.
  assign out_busy   = out_valid_q && !out_ready_i;

  assign in_ready_o  = !fifo_full;
  assign ack_o       = ack_q;
  assign rdata_o     = rdata_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  // STATUS image, LSB first: empty, full, out_valid, underflow, count.
  always_comb begin
    status_w              = '0;
    status_w[0]           = fifo_empty;
    status_w[1]           = fifo_full;
    status_w[2]           = out_valid_q;
    status_w[3]           = underflow_q;
    status_w[4 +: CNT_W]  = count_q;
  end

  // FIFO pointer/count next state; simultaneous push and pop leaves the count unchanged.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer/count registers; reset discards contents by emptying the pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents need no reset since the count gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  // Bus FSM with registered ACK/RDATA, outbound holding register and sticky underflow flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      underflow_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      // Consumer drain; a DATA_OUT store latched below in the same cycle overrides this.
      if (out_valid_q && out_ready_i) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (req_vld) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
            if (we_i) begin
              if (addr_i == ADDR_DOUT) begin
                if (out_busy) begin
                  state_q <= ST_WAIT_OUT;
                  ack_q   <= 1'b0;
                end else begin
                  out_data_q  <= wdata_i;
                  out_valid_q <= 1'b1;
                end
              end
            end else begin
              case (addr_i)
                ADDR_DIN: begin
                  if (fifo_empty) begin
                    rdata_q     <= '0;
                    underflow_q <= 1'b1;
                  end else begin
                    rdata_q <= mem_q[rd_ptr_q];
                  end
                end
                ADDR_DOUT: rdata_q <= out_data_q;
                ADDR_STAT: begin
                  rdata_q     <= status_w;
                  underflow_q <= 1'b0;
                end
                default:   rdata_q <= '0;
              endcase
            end
          end
        end
        ST_WAIT_OUT: begin
          // The CPU holds REQ and WDATA until ACK, so WDATA is still the stalled store's data.
          if (!out_busy) begin
            out_data_q  <= wdata_i;
            out_valid_q <= 1'b1;
            state_q     <= ST_ACK;
            ack_q       <= 1'b1;
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jala_io_responder.sv
// Bench for jala_io_responder: directed table, hand-written corner sequences, randomized run against a transaction-level model.
// Timing: inputs driven and outputs sampled on the falling edge of clk.
// Backpressure: random IN_VALID/OUT_READY exercise FIFO-full blocking and DATA_OUT stalls.
module tb_jala_io_responder;

  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst, sel, req, we;
  logic [1:0]  addr;
  logic [15:0] wdata, rdata, in_data, out_data;
  logic        ack, in_valid, in_ready, out_valid, out_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jala_io_responder #(.DATA_W(16), .FIFO_DEPTH(FD), .CNT_W(3)) dut (
    .clk_i(clk), .rst_i(rst), .sel_i(sel), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .ack_o(ack),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One bus access; optionally presents an inbound word across the same request edge.
  task automatic do_access(input logic w, input logic [1:0] a, input logic [15:0] d,
                           input logic pv, input logic [15:0] pd,
                           output logic [15:0] rd, output int lat);
    @(negedge clk);
    sel = 1'b1; req = 1'b1; we = w; addr = a; wdata = d;
    in_valid = pv; in_data = pd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      in_valid = 1'b0;
    end while (!ack && lat < 20);
    rd  = rdata;
    sel = 1'b0; req = 1'b0;
    if (!ack) chk("access_timeout", 32'(lat), 32'd0);
  endtask

  task automatic push_word(input logic [15:0] d);
    @(negedge clk);
    in_valid = 1'b1; in_data = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; sel = 1'b0; req = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [15:0] fifo_m[$];
  bit          ov_m, uf_m;
  logic [15:0] od_m;
  bit          pending, exp_ack, exp_is_load;
  bit          p_we;
  logic [1:0]  p_addr;
  logic [15:0] p_wdata, exp_rd;

  function automatic logic [15:0] status_m();
    int s;
    s = fifo_m.size();
    return 16'(s * 16 + (uf_m ? 8 : 0) + (ov_m ? 4 : 0) + (s == FD ? 2 : 0) + (s == 0 ? 1 : 0));
  endfunction

  // Effect of the coming clock edge given the inputs currently driven.
  task automatic model_step();
    int          sz0;
    bit          ov0, load_out, push_ok;
    logic [15:0] st0;
    sz0 = fifo_m.size(); ov0 = ov_m; st0 = status_m(); load_out = 0;
    push_ok = in_valid && (sz0 < FD);
    exp_ack = 0;
    if (pending && !(p_we && p_addr == 2'd1 && ov0 && !out_ready)) begin
      pending = 0; exp_ack = 1; exp_is_load = !p_we;
      if (p_we) begin
        if (p_addr == 2'd1) begin od_m = p_wdata; load_out = 1; end
      end else begin
        case (p_addr)
          2'd0: if (sz0 > 0) exp_rd = fifo_m.pop_front(); else begin exp_rd = 16'h0; uf_m = 1; end
          2'd1: exp_rd = od_m;
          2'd2: begin exp_rd = st0; uf_m = 0; end
          default: exp_rd = 16'h0;
        endcase
      end
    end
    if (push_ok) fifo_m.push_back(in_data);
    if (load_out) ov_m = 1;
    else if (ov0 && out_ready) ov_m = 0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t        tbl[12];
  logic [15:0] rd;
  int          lat;

  initial begin
    // Directed table from a clean reset, OUT_READY=0, no inbound traffic.
    tbl[0]  = '{1'b0, 2'd2, 16'h0000, 16'h0001};
    tbl[1]  = '{1'b1, 2'd1, 16'h1234, 16'h0000};
    tbl[2]  = '{1'b0, 2'd1, 16'h0000, 16'h1234};
    tbl[3]  = '{1'b0, 2'd2, 16'h0000, 16'h0005};
    tbl[4]  = '{1'b1, 2'd3, 16'h5A5A, 16'h0000};
    tbl[5]  = '{1'b0, 2'd3, 16'h0000, 16'h0000};
    tbl[6]  = '{1'b0, 2'd2, 16'h0000, 16'h0005};
    tbl[7]  = '{1'b0, 2'd0, 16'h0000, 16'h0000};
    tbl[8]  = '{1'b0, 2'd2, 16'h0000, 16'h000D};
    tbl[9]  = '{1'b0, 2'd2, 16'h0000, 16'h0005};
    tbl[10] = '{1'b1, 2'd2, 16'hFFFF, 16'h0000};
    tbl[11] = '{1'b0, 2'd2, 16'h0000, 16'h0005};

    rst = 1'b1; sel = 1'b0; req = 1'b0; we = 1'b0; addr = 2'd0; wdata = 16'h0;
    in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 1'b0);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 16'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b0, 16'h0, rd, lat);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd1);
      if (!tbl[i].we) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
    end
    chk("tbl_out_data_kept", out_data, 16'h1234);

    // REQ without SEL must not be answered.
    @(negedge clk);
    sel = 1'b0; req = 1'b1; we = 1'b0; addr = 2'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("nosel_ack", ack, 1'b0);
    end
    req = 1'b0;

    // Drain the held word, then fill the FIFO.
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("drain_out_valid", out_valid, 1'b0);
    out_ready = 1'b0;
    push_word(16'h1111); push_word(16'h2222); push_word(16'h3333); push_word(16'h4444);
    chk("full_in_ready", in_ready, 1'b0);
    do_access(1'b0, 2'd2, 16'h0, 1'b0, 16'h0, rd, lat);
    chk("full_status", rd, 16'h0042);
    // Pop while full with a producer word offered: the word must not enter.
    do_access(1'b0, 2'd0, 16'h0, 1'b1, 16'h9999, rd, lat);
    chk("fill_rd0", rd, 16'h1111);
    chk("fill_lat0", 32'(lat), 32'd1);
    do_access(1'b0, 2'd2, 16'h0, 1'b0, 16'h0, rd, lat);
    chk("fill_status3", rd, 16'h0030);
    do_access(1'b0, 2'd0, 16'h0, 1'b0, 16'h0, rd, lat);
    chk("fill_rd1", rd, 16'h2222);
    do_access(1'b0, 2'd0, 16'h0, 1'b0, 16'h0, rd, lat);
    chk("fill_rd2", rd, 16'h3333);
    do_access(1'b0, 2'd0, 16'h0, 1'b0, 16'h0, rd, lat);
    chk("fill_rd3", rd, 16'h4444);
    chk("fill_lat3", 32'(lat), 32'd1);
    do_access(1'b0, 2'd2, 16'h0, 1'b0, 16'h0, rd, lat);
    chk("drain_status", rd, 16'h0001);

    // Simultaneous push and pop at two entries.
    push_word(16'h00A1); push_word(16'h00A2);
    do_access(1'b0, 2'd0, 16'h0, 1'b1, 16'h00A3, rd, lat);
    chk("pp_rd", rd, 16'h00A1);
    do_access(1'b0, 2'd2, 16'h0, 1'b0, 16'h0, rd, lat);
    chk("pp_status", rd, 16'h0020);
    do_access(1'b0, 2'd0, 16'h0, 1'b0, 16'h0, rd, lat);
    chk("pp_rd2", rd, 16'h00A2);
    do_access(1'b0, 2'd0, 16'h0, 1'b0, 16'h0, rd, lat);
    chk("pp_rd3", rd, 16'h00A3);
    do_access(1'b0, 2'd2, 16'h0, 1'b0, 16'h0, rd, lat);
    chk("pp_status_end", rd, 16'h0001);

    // Outbound stall: second store waits for the consumer.
    do_access(1'b1, 2'd1, 16'hBEEF, 1'b0, 16'h0, rd, lat);
    chk("stall_first_lat", 32'(lat), 32'd1);
    chk("stall_first_data", out_data, 16'hBEEF);
    @(negedge clk);
    sel = 1'b1; req = 1'b1; we = 1'b1; addr = 2'd1; wdata = 16'hCAFE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ack_held", ack, 1'b0);
      chk("stall_data_held", out_data, 16'hBEEF);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_ack", ack, 1'b1);
    chk("stall_data_new", out_data, 16'hCAFE);
    chk("stall_valid", out_valid, 1'b1);
    sel = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("stall_ack_pulse", ack, 1'b0);
    chk("stall_drained", out_valid, 1'b0);
    out_ready = 1'b0;

    // Reset in the middle of a stalled store with FIFO contents present.
    push_word(16'h0101); push_word(16'h0202);
    do_access(1'b1, 2'd1, 16'h3333, 1'b0, 16'h0, rd, lat);
    @(negedge clk);
    sel = 1'b1; req = 1'b1; we = 1'b1; addr = 2'd1; wdata = 16'h7777;
    @(negedge clk);
    chk("mrst_pre_ack", ack, 1'b0);
    rst = 1'b1; sel = 1'b0; req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mrst_ack", ack, 1'b0);
    end
    rst = 1'b0;
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_in_ready", in_ready, 1'b1);
    do_access(1'b0, 2'd2, 16'h0, 1'b0, 16'h0, rd, lat);
    chk("mrst_status", rd, 16'h0001);
    do_access(1'b0, 2'd0, 16'h0, 1'b0, 16'h0, rd, lat);
    chk("mrst_fifo_gone", rd, 16'h0000);

    // Randomized run against the model.
    pulse_reset();
    fifo_m.delete(); ov_m = 0; uf_m = 0; od_m = 16'h0;
    pending = 0; exp_ack = 0; exp_is_load = 0; exp_rd = 16'h0;
    p_we = 0; p_addr = 2'd0; p_wdata = 16'h0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      chk("rnd_ack", ack, exp_ack);
      if (exp_ack && exp_is_load) chk("rnd_rdata", rdata, exp_rd);
      chk("rnd_in_ready", in_ready, fifo_m.size() < FD);
      chk("rnd_out_valid", out_valid, ov_m);
      if (ov_m) chk("rnd_out_data", out_data, od_m);
      if (exp_ack) begin
        sel = 1'b0; req = 1'b0;
      end else if (!pending && $urandom_range(0, 2) == 0) begin
        we = 1'($urandom_range(0, 1));
        addr = 2'($urandom_range(0, 3));
        wdata = 16'($urandom);
        sel = 1'b1; req = 1'b1;
        pending = 1; p_we = we; p_addr = addr; p_wdata = wdata;
      end
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      model_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
